tank_sprite_renderer: RTL and testbench
=======================================

# tank_sprite_renderer

Parametrised tank sprite pixel generator for the VGA draw path: given the current scan coordinate, it reports whether the pixel lies on a tank and returns its 12-bit colour. All four facings come from one up-facing ROM image via address rotation, and any of NUM_TEAMS palettes can be selected. A frame-synchronous hit-flash effect is included. Position, direction and team are latched once per frame so a tank never tears mid-scan. One instance per tank feeds the playfield compositor.

## Interface
- SPRITE_SIZE, 32: square sprite edge in pixels; ROM depth SPRITE_SIZE².
- NUM_TEAMS, 4: palette count; team 0 is the player.
- IDX_W, 2: ROM palette index width; index 0 is transparent.
- FLASH_FRAMES, 16: frames of flash after a hit.
- clk  in  1  pixel clock.
- rst_n  in  1  reset, synchronous, active-low.
- frame_start  in  1  one-cycle pulse at the start of vertical blank.
- tank_x, tank_y  in  10 each  top-left screen position; sampled on frame_start.
- dir  in  2  facing: 0 up, 1 right, 2 down, 3 left; sampled on frame_start.
- team  in  $clog2(NUM_TEAMS)  palette select; sampled on frame_start.
- hit  in  1  one-cycle pulse; starts or restarts the flash.
- pix_valid  in  1  draw_x/draw_y valid this cycle.
- draw_x, draw_y  in  10 each  scan coordinate.
- out_valid  out  1  pix_valid delayed 3 cycles.
- opaque  out  1  pixel is inside the sprite box and ROM index ≠ 0.
- red, green, blue  out  4 each  colour; 0 when !opaque.
- flashing  out  1  flash counter nonzero.

## Operation
- Latched registers x_l, y_l, dir_l, team_l load on frame_start. Reset value: 0.
- Local coordinates: u = draw_x − x_l, v = draw_y − y_l, computed 11-bit signed. in_box = 0 ≤ u < SPRITE_SIZE and 0 ≤ v < SPRITE_SIZE. Boxes partially off-screen are legal; no wrap at 1023.
- Source pixel (row, col) in the up-facing image, with S = SPRITE_SIZE−1:
  - up: (v, u)
  - right: (S−u, v)
  - down: (S−v, S−u)
  - left: (u, S−v)
- ROM address = row·SPRITE_SIZE + col, width $clog2(SPRITE_SIZE²).
- The palette is a constant lookup [team_l][index]. An index of 0 or !in_box forces opaque=0 and rgb=0.
- Flash FSM has two states, IDLE and FLASH, with counter cnt of width $clog2(FLASH_FRAMES+1).
  - hit loads cnt = FLASH_FRAMES and enters FLASH.
  - In FLASH, frame_start decrements cnt. Return to IDLE when cnt reaches 0.
  - hit and frame_start in the same cycle: the reload wins and there is no decrement.
  - hit during FLASH restarts the count.
- Blink: while cnt[1] = 1, opaque pixels output 4'hF on all channels (white). This gives a 2-frames-on/2-frames-off pattern. Otherwise the palette colour is used.
- The flash state used for a pixel is the one sampled at stage 1, alongside that pixel.

## Timing
- Pipeline, with pixel accepted at cycle N:
  - N+1: register rom_addr, in_box, team_l, blink, valid.
  - N+2: synchronous ROM q available; delay the side-band bits by one stage.
  - N+3: registered outputs.
- Total latency 3, throughput 1 pixel/clock, no stalls. Bubbles (pix_valid=0) propagate as out_valid=0, with opaque=0 and rgb=0.
- Latched registers update the cycle after frame_start. Pixels presented in the frame_start cycle use the old values.
- Reset (rst_n=0 at a rising edge):
  - All pipeline valids, opaque, rgb, flashing, cnt, x_l, y_l, dir_l, team_l go to 0.
  - FSM goes to IDLE.
  - In-flight pixels are discarded.
  - Outputs are 0 starting the cycle after the reset edge.
- flashing is registered and asserts the cycle after hit.

## Structure
- Shared package tank_pkg holds:
  - dir_t enum (UP, RIGHT, DOWN, LEFT)
  - the flash_state_t enum
  - the 12-bit team palette constant array TEAM_PALETTE[NUM_TEAMS][2**IDX_W]
  - the transparent index constant
- Sub-module: tank_up_rom, the generated synchronous block ROM (one-cycle read latency), instantiated once.
- Palette lookup and FSM stay inline.

## Test plan
- Up, team 0, tank at (100,50), scan pixel (100,50):
  - required: out_valid exactly 3 cycles later
  - required: rgb = TEAM_PALETTE[0][rom[0]]
  - required: opaque = (rom[0] ≠ 0)
- Tank at (100,50), pixel (132,50), then pixel (99,50): opaque=0, rgb=0 for both.
- Rotation, pixel local (u=0, v=5) with SPRITE_SIZE=32:
  - left fetches addr 26
  - right fetches addr 31·32+5
  - down fetches addr 26·32+31
  - check each against a model.
- Flash:
  - hit → flashing=1 next cycle.
  - Count frame_start pulses: white on opaque pixels only while cnt[1] = 1.
  - flashing drops after exactly 16 frame_starts.
  - hit together with frame_start → cnt reload to 16.
- Change dir and team mid-frame: output is unchanged until after the next frame_start, with no mixed-facing frame.
- Assert rst_n=0 with 3 pixels in flight and flash active: out_valid, opaque, rgb and flashing are all 0 the next cycle. After release, the first pixel emerges with latency 3.

Source files
------------

// File: rtl/tank_pkg.sv
// Shared types and constants for the tank sprite renderer: facings, flash FSM
// states and the per-team 12-bit palettes (index 0 of every palette is unused).
package tank_pkg;

    localparam int PKG_SPRITE_SIZE  = 32;
    localparam int PKG_NUM_TEAMS    = 4;
    localparam int PKG_IDX_W        = 2;
    localparam int PKG_FLASH_FRAMES = 16;

    localparam logic [PKG_IDX_W-1:0] TRANSPARENT_IDX = '0;

    typedef enum logic [1:0] {
        UP    = 2'd0,
        RIGHT = 2'd1,
        DOWN  = 2'd2,
        LEFT  = 2'd3
    } dir_t;

    typedef enum logic {
        IDLE  = 1'b0,
        FLASH = 1'b1
    } flash_state_t;

    // Team 0 is the player (green); colours are packed {r, g, b}.
    localparam logic [11:0] TEAM_PALETTE [PKG_NUM_TEAMS][2**PKG_IDX_W] = '{
        '{12'h000, 12'h2A2, 12'h4C4, 12'h8F8},
        '{12'h000, 12'h622, 12'hC44, 12'hF88},
        '{12'h000, 12'h226, 12'h44C, 12'h88F},
        '{12'h000, 12'h662, 12'hCC4, 12'hFF8}
    };

endpackage

// File: rtl/tank_up_rom.sv
// Up-facing tank image as a synchronous ROM (one-cycle read latency).
// The image is drawn on a 32x32 grid and scaled to SPRITE_SIZE.
module tank_up_rom #(
    parameter int SPRITE_SIZE = 32,
    parameter int IDX_W       = 2
) (
    input  logic                                     clk_i,
    input  logic [$clog2(SPRITE_SIZE*SPRITE_SIZE)-1:0] addr_i,
    output logic [IDX_W-1:0]                         idx_o
);

    logic [IDX_W-1:0] idx_q;

    // Later shapes paint over earlier ones: tracks, hull, turret, hatch, barrel.
    function automatic logic [IDX_W-1:0] image_idx(input int row, input int col);
        int r;
        int c;
        logic [IDX_W-1:0] idx;
        r   = (row * 32) / SPRITE_SIZE;
        c   = (col * 32) / SPRITE_SIZE;
        idx = '0;
        if (r >= 2 && r <= 29 && ((c >= 2 && c <= 7) || (c >= 24 && c <= 29)))
            idx = IDX_W'(1);
        if (r >= 6 && r <= 27 && c >= 8 && c <= 23)
            idx = IDX_W'(2);
        if (r >= 10 && r <= 19 && c >= 12 && c <= 19)
            idx = IDX_W'(3);
        if (r >= 12 && r <= 13 && c >= 17 && c <= 18)
            idx = IDX_W'(1);
        if (r <= 11 && c >= 15 && c <= 16)
            idx = IDX_W'(3);
        return idx;
    endfunction

    always_ff @(posedge clk_i) begin
        idx_q <= image_idx(int'(addr_i) / SPRITE_SIZE, int'(addr_i) % SPRITE_SIZE);
    end

    assign idx_o = idx_q;

endmodule

// File: rtl/tank_sprite_renderer.sv
// Per-tank pixel generator: frame-latched placement, rotated ROM fetch,
// team palette and hit-flash blink, in a 3-stage pipeline.
module tank_sprite_renderer
    import tank_pkg::*;
#(
    parameter int SPRITE_SIZE  = PKG_SPRITE_SIZE,
    parameter int NUM_TEAMS    = PKG_NUM_TEAMS,
    parameter int IDX_W        = PKG_IDX_W,
    parameter int FLASH_FRAMES = PKG_FLASH_FRAMES
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         frame_start,
    input  logic [9:0]                   tank_x,
    input  logic [9:0]                   tank_y,
    input  logic [1:0]                   dir,
    input  logic [$clog2(NUM_TEAMS)-1:0] team,
    input  logic                         hit,
    input  logic                         pix_valid,
    input  logic [9:0]                   draw_x,
    input  logic [9:0]                   draw_y,
    output logic                         out_valid,
    output logic                         opaque,
    output logic [3:0]                   red,
    output logic [3:0]                   green,
    output logic [3:0]                   blue,
    output logic                         flashing
);

    localparam int LW = $clog2(SPRITE_SIZE);
    localparam int AW = $clog2(SPRITE_SIZE * SPRITE_SIZE);
    localparam int TW = $clog2(NUM_TEAMS);
    localparam int CW = $clog2(FLASH_FRAMES + 1);
    localparam logic [LW-1:0] S = LW'(SPRITE_SIZE - 1);

    logic [9:0]    x_l_q, y_l_q;
    dir_t          dir_l_q;
    logic [TW-1:0] team_l_q;

    flash_state_t  state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic signed [10:0] u, v;
    logic               in_box;
    logic [LW-1:0]      lu, lv, row, col;
    logic [AW-1:0]      addr_d;

    logic [AW-1:0]    addr_q;
    logic             in_box1_q, blink1_q, valid1_q;
    logic [TW-1:0]    team1_q;
    logic             in_box2_q, blink2_q, valid2_q;
    logic [TW-1:0]    team2_q;
    logic [IDX_W-1:0] rom_idx;

    logic        opaque_d, opaque_q, out_valid_q;
    logic [11:0] rgb_d, rgb_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            x_l_q    <= '0;
            y_l_q    <= '0;
            dir_l_q  <= UP;
            team_l_q <= '0;
        end else if (frame_start) begin
            x_l_q    <= tank_x;
            y_l_q    <= tank_y;
            dir_l_q  <= dir_t'(dir);
            team_l_q <= team;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // A hit reload takes priority over a same-cycle frame decrement.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (hit) begin
            state_d = FLASH;
            cnt_d   = CW'(FLASH_FRAMES);
        end else if (state_q == FLASH && frame_start) begin
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1))
                state_d = IDLE;
        end
    end

    // Local coordinates are signed so boxes hanging off the left/top never wrap.
    always_comb begin
        u      = signed'({1'b0, draw_x}) - signed'({1'b0, x_l_q});
        v      = signed'({1'b0, draw_y}) - signed'({1'b0, y_l_q});
        in_box = !u[10] && !v[10] &&
                 (u[9:0] < 10'(SPRITE_SIZE)) && (v[9:0] < 10'(SPRITE_SIZE));
        lu     = u[LW-1:0];
        lv     = v[LW-1:0];
        row    = lv;
        col    = lu;
        case (dir_l_q)
            UP:    begin row = lv;     col = lu;     end
            RIGHT: begin row = S - lu; col = lv;     end
            DOWN:  begin row = S - lv; col = S - lu; end
            LEFT:  begin row = lu;     col = S - lv; end
            default: ;
        endcase
        addr_d = AW'(int'(row) * SPRITE_SIZE + int'(col));
    end

    tank_up_rom #(
        .SPRITE_SIZE(SPRITE_SIZE),
        .IDX_W      (IDX_W)
    ) u_rom (
        .clk_i (clk),
        .addr_i(addr_q),
        .idx_o (rom_idx)
    );

    always_comb begin
        opaque_d = valid2_q && in_box2_q && (rom_idx != IDX_W'(TRANSPARENT_IDX));
        rgb_d    = '0;
        if (opaque_d)
            rgb_d = blink2_q ? 12'hFFF : TEAM_PALETTE[team2_q][rom_idx];
    end

    // Side-band bits ride alongside the ROM read so they line up with its data.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            addr_q      <= '0;
            in_box1_q   <= 1'b0;
            team1_q     <= '0;
            blink1_q    <= 1'b0;
            valid1_q    <= 1'b0;
            in_box2_q   <= 1'b0;
            team2_q     <= '0;
            blink2_q    <= 1'b0;
            valid2_q    <= 1'b0;
            out_valid_q <= 1'b0;
            opaque_q    <= 1'b0;
            rgb_q       <= '0;
        end else begin
            addr_q      <= addr_d;
            in_box1_q   <= in_box;
            team1_q     <= team_l_q;
            blink1_q    <= cnt_q[1];
            valid1_q    <= pix_valid;
            in_box2_q   <= in_box1_q;
            team2_q     <= team1_q;
            blink2_q    <= blink1_q;
            valid2_q    <= valid1_q;
            out_valid_q <= valid2_q;
            opaque_q    <= opaque_d;
            rgb_q       <= rgb_d;
        end
    end

    assign out_valid = out_valid_q;
    assign opaque    = opaque_q;
    assign red       = rgb_q[11:8];
    assign green     = rgb_q[7:4];
    assign blue      = rgb_q[3:0];
    assign flashing  = (state_q == FLASH);

endmodule

// File: tb/tb_tank_sprite_renderer.sv
// Self-checking bench for tank_sprite_renderer: directed scenarios plus random
// traffic, compared every cycle against a shape/rotation/palette reference model.
module tb_tank_sprite_renderer;

    logic       clk = 1'b0;
    logic       rst_n, frame_start, hit, pix_valid;
    logic [9:0] tank_x, tank_y, draw_x, draw_y;
    logic [1:0] dir, team;
    logic       out_valid, opaque, flashing;
    logic [3:0] red, green, blue;

    tank_sprite_renderer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .frame_start(frame_start),
        .tank_x     (tank_x),
        .tank_y     (tank_y),
        .dir        (dir),
        .team       (team),
        .hit        (hit),
        .pix_valid  (pix_valid),
        .draw_x     (draw_x),
        .draw_y     (draw_y),
        .out_valid  (out_valid),
        .opaque     (opaque),
        .red        (red),
        .green      (green),
        .blue       (blue),
        .flashing   (flashing)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        v;
        logic        o;
        logic [11:0] rgb;
    } exp_t;

    // Up-facing image as rectangles {row0,row1,col0,col1,index}; later entries win.
    localparam int RECTS [6][5] = '{
        '{2, 29, 2, 7, 1}, '{2, 29, 24, 29, 1}, '{6, 27, 8, 23, 2},
        '{10, 19, 12, 19, 3}, '{12, 13, 17, 18, 1}, '{0, 11, 15, 16, 3}
    };
    localparam int PAL [4][4] = '{
        '{'h000, 'h2A2, 'h4C4, 'h8F8}, '{'h000, 'h622, 'hC44, 'hF88},
        '{'h000, 'h226, 'h44C, 'h88F}, '{'h000, 'h662, 'hCC4, 'hFF8}
    };
    localparam int SZ = 32;

    int   checkCount = 0;
    int   failCount  = 0;
    int   mX = 0, mY = 0, mDir = 0, mTeam = 0, mCnt = 0;
    exp_t pipe [3];

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checkCount++;
        if (observed != expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    function automatic int imgIdx(input int row, input int col);
        int idx = 0;
        for (int k = 0; k < 6; k++)
            if (row >= RECTS[k][0] && row <= RECTS[k][1] && col >= RECTS[k][2] && col <= RECTS[k][3])
                idx = RECTS[k][4];
        return idx;
    endfunction

    function automatic exp_t modelPixel();
        exp_t e;
        int u, v, row, col, idx;
        e = '0;
        if (!pix_valid) return e;
        e.v = 1'b1;
        u = int'(draw_x) - mX;
        v = int'(draw_y) - mY;
        if (u < 0 || u >= SZ || v < 0 || v >= SZ) return e;
        case (mDir)
            0:       begin row = v;          col = u;          end
            1:       begin row = SZ - 1 - u; col = v;          end
            2:       begin row = SZ - 1 - v; col = SZ - 1 - u; end
            default: begin row = u;          col = SZ - 1 - v; end
        endcase
        idx = imgIdx(row, col);
        if (idx == 0) return e;
        e.o   = 1'b1;
        e.rgb = ((mCnt & 2) != 0) ? 12'hFFF : 12'(PAL[mTeam][idx]);
        return e;
    endfunction

    // One clock: model the pixel and state update, then compare after the edge.
    task automatic tick();
        exp_t e;
        e = modelPixel();
        if (!rst_n) begin
            mX = 0; mY = 0; mDir = 0; mTeam = 0; mCnt = 0;
            e = '0;
            pipe[0] = '0; pipe[1] = '0; pipe[2] = '0;
        end else begin
            if (frame_start) begin
                mX = int'(tank_x); mY = int'(tank_y); mDir = int'(dir); mTeam = int'(team);
            end
            if (hit) mCnt = 16;
            else if (frame_start && mCnt > 0) mCnt--;
        end
        @(posedge clk);
        #1;
        pipe[2] = pipe[1];
        pipe[1] = pipe[0];
        pipe[0] = e;
        checkOutput("out_valid", int'(out_valid), int'(pipe[2].v));
        checkOutput("opaque", int'(opaque), int'(pipe[2].o));
        checkOutput("rgb", int'({red, green, blue}), int'(pipe[2].rgb));
        checkOutput("flashing", int'(flashing), int'(mCnt != 0));
    endtask

    task automatic applyStimulus(input bit fs, input bit h, input bit pv, input int x, input int y);
        frame_start = fs;
        hit         = h;
        pix_valid   = pv;
        draw_x      = 10'(x);
        draw_y      = 10'(y);
        tick();
    endtask

    task automatic pixel(input int x, input int y);
        applyStimulus(0, 0, 1, x, y);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0);
    endtask

    initial begin
        rst_n = 1'b0; tank_x = '0; tank_y = '0; dir = '0; team = '0;
        idle(2);
        rst_n = 1'b1;

        tank_x = 10'd100; tank_y = 10'd50; dir = 2'd0; team = 2'd0;
        applyStimulus(1, 0, 0, 0, 0);
        pixel(100, 50);
        idle(1);
        pixel(132, 50);
        pixel(99, 50);
        pixel(115, 60);
        pixel(115, 52);
        pixel(105, 52);
        idle(4);

        for (int d = 1; d < 4; d++) begin
            dir = 2'(d);
            applyStimulus(1, 0, 0, 0, 0);
            pixel(100, 55);
            pixel(120, 53);
            pixel(131, 81);
            idle(3);
        end

        dir = 2'd0; team = 2'd1;
        applyStimulus(1, 0, 0, 0, 0);
        applyStimulus(0, 1, 1, 115, 65);
        for (int f = 0; f < 25; f++) begin
            applyStimulus(1, (f == 5), 1, 115, 65);
            pixel(101, 50);
            pixel(102, 60);
            pixel(110, 70);
        end
        idle(3);

        dir = 2'd2; team = 2'd3;
        pixel(115, 52);
        pixel(105, 52);
        idle(3);
        applyStimulus(1, 0, 1, 115, 52);
        pixel(115, 52);
        pixel(105, 52);
        idle(4);

        applyStimulus(0, 1, 0, 0, 0);
        pixel(105, 52);
        pixel(115, 60);
        pixel(110, 70);
        rst_n = 1'b0;
        pixel(115, 52);
        rst_n = 1'b1;
        pixel(5, 5);
        idle(4);

        for (int c = 0; c < 3000; c++) begin
            int  dx, dy;
            bit  fs, h, pv;
            if ($urandom_range(0, 49) == 0) begin
                tank_x = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(990, 1023)) : 10'($urandom_range(0, 1023));
                tank_y = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(990, 1023)) : 10'($urandom_range(0, 1023));
                dir    = 2'($urandom);
                team   = 2'($urandom);
            end
            fs = ($urandom_range(0, 79) == 0);
            h  = ($urandom_range(0, 99) == 0);
            pv = ($urandom_range(0, 4) != 0);
            dx = mX + int'($urandom_range(0, 40)) - 4;
            dy = mY + int'($urandom_range(0, 40)) - 4;
            rst_n = ($urandom_range(0, 999) != 0);
            applyStimulus(fs, h, pv, dx, dy);
            rst_n = 1'b1;
        end
        idle(4);

        $display("== %0d vectors applied, %0d miscompares ==", checkCount, failCount);
        $finish;
    end

endmodule
